// File: rtl/mtsp_sf_sched.sv
// Round-robin issue of per-requester special-function operations to one shared
// fixed-latency unit; a tag pipeline routes each result back to its requester.
module mtsp_sf_sched #(
  parameter int N_REQ  = 4,
  parameter int SF_LAT = 3,
  parameter int IDW    = $clog2(N_REQ)
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                ENABLE,
  input  logic [N_REQ-1:0]    REQ_VALID,
  input  logic [N_REQ*3-1:0]  REQ_OP,
  input  logic [N_REQ*32-1:0] REQ_DATA,
  output logic [N_REQ-1:0]    REQ_READY,
  output logic                SF_EN,
  output logic [2:0]          SF_OP,
  output logic [31:0]         SF_DIN,
  input  logic [31:0]         SF_DOUT,
  output logic                RES_VALID,
  output logic [IDW-1:0]      RES_ID,
  output logic [31:0]         RES_DATA,
  output logic [N_REQ-1:0]    OUTSTANDING,
  output logic                BUSY
);
  localparam int LAST = SF_LAT - 1;

  logic [IDW-1:0]   ptr_r;
  logic [IDW-1:0]   issue_id_r;
  logic             tag_vld_r [SF_LAT];
  logic [IDW-1:0]   tag_id_r  [SF_LAT];
  logic [N_REQ-1:0] eligible_s;
  logic [N_REQ-1:0] out_nxt_s;
  logic [IDW-1:0]   cand_s;
  logic [IDW-1:0]   grant_id_s;
  logic             grant_s;
  logic [2:0]       op_a_s   [N_REQ];
  logic [31:0]      data_a_s [N_REQ];

  // Unpack the flat operand buses into arrays indexed by requester ID.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      op_a_s[i]   = REQ_OP[3*i +: 3];
      data_a_s[i] = REQ_DATA[32*i +: 32];
    end
  end

  // Round-robin search from ptr_r; the first eligible index gets the grant.
  always_comb begin
    eligible_s = REQ_VALID & ~OUTSTANDING & {N_REQ{ENABLE}};
    grant_s    = 1'b0;
    grant_id_s = '0;
    cand_s     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand_s = ptr_r + IDW'(k);
      if (!grant_s && eligible_s[cand_s]) begin
        grant_s    = 1'b1;
        grant_id_s = cand_s;
      end else begin
        grant_id_s = grant_id_s;
      end
    end
    REQ_READY = '0;
    if (grant_s) begin
      REQ_READY[grant_id_s] = 1'b1;
    end else begin
      REQ_READY = '0;
    end
  end

  // Next in-flight set: clear the retiring ID, set the newly granted one.
  // A requester holds at most one operation, so both never hit the same bit.
  always_comb begin
    out_nxt_s = OUTSTANDING;
    if (tag_vld_r[LAST]) begin
      out_nxt_s[tag_id_r[LAST]] = 1'b0;
    end else begin
      out_nxt_s = out_nxt_s;
    end
    if (grant_s) begin
      out_nxt_s[grant_id_s] = 1'b1;
    end else begin
      out_nxt_s = out_nxt_s;
    end
  end

  // Issue stage: sample the granted operands and advance the pointer.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ptr_r      <= '0;
      issue_id_r <= '0;
      SF_EN      <= 1'b0;
      SF_OP      <= 3'd0;
      SF_DIN     <= 32'd0;
    end else begin
      SF_EN <= grant_s;
      if (grant_s) begin
        ptr_r      <= grant_id_s + IDW'(1'b1);
        issue_id_r <= grant_id_s;
        SF_OP      <= op_a_s[grant_id_s];
        SF_DIN     <= data_a_s[grant_id_s];
      end else begin
        ptr_r      <= ptr_r;
        issue_id_r <= issue_id_r;
        SF_OP      <= SF_OP;
        SF_DIN     <= SF_DIN;
      end
    end
  end

  // Tag pipeline, loaded alongside SF_EN so its last stage lines up with SF_DOUT.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int j = 0; j < SF_LAT; j++) begin
        tag_vld_r[j] <= 1'b0;
        tag_id_r[j]  <= '0;
      end
    end else begin
      tag_vld_r[0] <= SF_EN;
      tag_id_r[0]  <= issue_id_r;
      for (int j = 1; j < SF_LAT; j++) begin
        tag_vld_r[j] <= tag_vld_r[j-1];
        tag_id_r[j]  <= tag_id_r[j-1];
      end
    end
  end

  // Result capture and in-flight bookkeeping.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      RES_VALID   <= 1'b0;
      RES_ID      <= '0;
      RES_DATA    <= 32'd0;
      OUTSTANDING <= '0;
      BUSY        <= 1'b0;
    end else begin
      RES_VALID <= tag_vld_r[LAST];
      if (tag_vld_r[LAST]) begin
        RES_ID   <= tag_id_r[LAST];
        RES_DATA <= SF_DOUT;
      end else begin
        RES_ID   <= RES_ID;
        RES_DATA <= RES_DATA;
      end
      OUTSTANDING <= out_nxt_s;
      BUSY        <= |out_nxt_s;
    end
  end
endmodule
